// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
//
// Wishbone classic single-access bus master. Takes one command from a
// valid/ready stream, runs a single read or write cycle on the wbm_* pins,
// waits for ack (or gives up after TIMEOUT strobe cycles), and hands the
// result back on a valid/ready response stream. One access in flight at a
// time; no pipelining, no bursts.
//
// Parameters:
//   TIMEOUT   strobe cycles without ack before the access aborts (0 = never)
//   ERR_DATA  response data returned for an aborted access
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-low reset
//   enable_i                    allows new commands to be accepted
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_we_i, cmd_adr_i,        command fields (write flag, byte address,
//   cmd_dat_i, cmd_sel_i          write data, byte selects)
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o        read data (0 for writes, ERR_DATA on abort),
//                                 abort flag
//   wbm_cyc_o .. wbm_dat_o      Wishbone master outputs
//   wbm_ack_i, wbm_dat_i        Wishbone slave ack and read data
//   busy_o                      access in flight or response pending
//   txn_cnt_o                   completed good accesses (wraps)
//   err_cnt_o                   aborted accesses (saturates)
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready_o follows enable_i
// BUS    | cyc/stb asserted, waiting for ack or timeout
// RESP   | response held on rsp_* until the consumer takes it
// ---------------------------------------------------------------------------
module wb_initiator #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable_i,

  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,

  output logic        busy_o,
  output logic [15:0] txn_cnt_o,
  output logic [7:0]  err_cnt_o
);

  // Counter must hold TIMEOUT itself; keep at least one bit so TIMEOUT=0
  // still elaborates (the counter is simply never consulted then).
  localparam int unsigned    TMO_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(1);
  localparam bit             TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy_o      <= 1'b0;
      txn_cnt_o   <= '0;
      err_cnt_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            tmo_cnt     <= TMO_LOAD;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ST_BUS;
          end else begin
            cmd_ready_o <= enable_i;
          end
        end

        ST_BUS: begin
          cmd_ready_o <= 1'b0;
          // Ack is checked first so an ack landing on the final strobe
          // cycle still produces a normal response.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            // tmo_cnt reaching 1 here means stb has now been high for
            // TIMEOUT cycles.
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= ERR_DATA;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt - TMO_LAST;
          end
        end

        ST_RESP: begin
          cmd_ready_o <= 1'b0;
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
            if (rsp_err_o) begin
              if (err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
              end
            end else begin
              txn_cnt_o <= txn_cnt_o + 16'd1;
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          cmd_ready_o <= 1'b0;
          rsp_valid_o <= 1'b0;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
